// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side FIFO for a UART: buffers words produced by the receiver's
//   done tick until the consumer pops them. Show-ahead read port: the head
//   word is always presented on o_r_data while the FIFO is not empty.
//
// Ports
//   i_clk       clock, rising edge active
//   i_reset     asynchronous, active-high reset (pointers/count/flag only)
//   i_wr        write strobe (one-cycle pulse from the receiver)
//   i_w_data    word captured when i_wr=1
//   i_rd        pop strobe from the consumer
//   o_r_data    head-of-queue word (don't-care while o_empty=1)
//   o_empty     count == 0
//   o_full      count == DEPTH
//   o_count     number of stored words, 0..DEPTH
//   o_overflow  sticky: a word was dropped because the FIFO was full
//   i_clr_ovf   synchronous clear of o_overflow (a coincident drop wins)
//
// Strobe semantics: i_wr and i_rd are level-sampled on every rising edge.
// A write is accepted when not full, or when full and a pop happens on the
// same edge. A pop is accepted only when not empty. Neither side stalls; a
// write that cannot be accepted is dropped and flagged via o_overflow.

module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [DBIT-1:0]   i_w_data,
  input  logic              i_rd,
  output logic [DBIT-1:0]   o_r_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;

  logic do_rd;
  logic do_wr;
  logic drop;

  assign o_empty    = (count == '0);
  assign o_full     = (count == FULL_COUNT);
  assign o_count    = count;
  assign o_overflow = overflow;
  assign o_r_data   = mem[rd_ptr];

  // When full, a simultaneous pop frees the slot being written, so the
  // write goes ahead. When empty, a simultaneous pop is ignored (no bypass).
  assign do_rd = i_rd && !o_empty;
  assign do_wr = i_wr && (!o_full || do_rd);
  assign drop  = i_wr && o_full && !i_rd;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= i_w_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo: directed vector table, hand-written
//   corner sequences (fill/overflow, full read+write, async reset, flag
//   clear) and a randomized run checked against a queue-based model.

module tb_uart_rx_fifo;

  localparam int DBIT  = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr = 1'b0;
  logic            rd = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [DBIT-1:0] w_data = '0;
  logic [DBIT-1:0] r_data;
  logic            empty;
  logic            full;
  logic [4:0]      count;
  logic            overflow;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DBIT(DBIT), .ADDR_W(4)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_wr       (wr),
    .i_w_data   (w_data),
    .i_rd       (rd),
    .o_r_data   (r_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow),
    .i_clr_ovf  (clr_ovf)
  );

  // ---------------- scoreboard / model ----------------
  logic [DBIT-1:0] exp_q[$];
  logic            exp_ovf = 1'b0;
  logic [DBIT-1:0] last_pop = '0;
  int              vectors = 0;
  int              miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic chk_model();
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() > 0) chk("head", 32'(r_data), 32'(exp_q[0]));
  endtask

  // Apply one cycle of strobes (called #1 after a rising edge), advance the
  // model by the FIFO's rules, then check #1 after the next rising edge.
  task automatic step(input logic w, input logic r, input logic c, input logic [DBIT-1:0] d);
    int  n;
    bit  popped;
    n = exp_q.size();
    wr = w; rd = r; clr_ovf = c; w_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    popped = r && (n > 0);
    if (popped) last_pop = exp_q.pop_front();
    if (w && (n < DEPTH || popped)) exp_q.push_back(d);
    if (w && n == DEPTH && !r) exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    chk_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            w;
    logic            r;
    logic            c;
    logic [DBIT-1:0] d;
    logic [4:0]      e_count;
    logic            e_empty;
    logic            e_full;
    logic            e_ovf;
    logic            chk_data;
    logic [DBIT-1:0] e_data;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h42, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h43, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    // pop on empty is ignored
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    // write+pop on empty: write only, no bypass
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h7E, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E};
    // write+pop with one word: count unchanged, new word becomes head
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h99, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
  end

  // ---------------- test sequence ----------------
  initial begin
    int wr_pct;
    int rd_pct;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), 32'(r_data), 32'(tbl[i].e_data));
    end

    // Fill to full, drop a 17th word, drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(r_data), 32'(i));
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous write+pop: both happen, no overflow.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("fullrw_count", 32'(count), 32'd16);
    chk("fullrw_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fullrw_last", 32'(last_pop), 32'h55);

    // Drop and clear on the same edge: the drop wins.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 16));
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    chk("set_wins", 32'(overflow), 32'd1);

    // Async reset between edges with words held; overflow is still set.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_reset_count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_ovf", 32'(overflow), 32'd0);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 8'h11);
    chk("post_reset_data", 32'(r_data), 32'h11);
    chk("post_reset_count", 32'(count), 32'd1);

    // Set overflow again, then clear it with i_clr_ovf alone.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 64));
    chk("reovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_keeps_data", 32'(count), 32'd16);

    // Randomized phases biasing toward fill, drain and balanced traffic so
    // the pointers wrap many times and both boundaries are exercised.
    for (int p = 0; p < 12; p++) begin
      case (p % 3)
        0: begin wr_pct = 80; rd_pct = 30; end
        1: begin wr_pct = 30; rd_pct = 80; end
        default: begin wr_pct = 60; rd_pct = 60; end
      endcase
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) < wr_pct,
             $urandom_range(0, 99) < rd_pct,
             $urandom_range(0, 99) < 5,
             8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
